// File: rtl/bali_pkg.sv
// Shared definitions for the bali bytecode core.
// Contents:
//   - opcode constants used by the fetch stage and the decoder
//   - fetch_state_t : fetch-stage state machine encoding
//   - ARGC_W / argc_t : operand-count width and type
package bali_pkg;

  localparam int ARGC_W = 2;
  typedef logic [ARGC_W-1:0] argc_t;

  localparam logic [7:0] OP_BIPUSH       = 8'h10;
  localparam logic [7:0] OP_SIPUSH       = 8'h11;
  localparam logic [7:0] OP_LDC          = 8'h12;
  localparam logic [7:0] OP_ILOAD        = 8'h15;
  localparam logic [7:0] OP_ISTORE       = 8'h36;
  localparam logic [7:0] OP_IINC         = 8'h84;
  localparam logic [7:0] OP_IF_FIRST     = 8'h99;  // ifeq
  localparam logic [7:0] OP_IF_LAST      = 8'ha6;  // if_acmpne
  localparam logic [7:0] OP_GOTO         = 8'ha7;
  localparam logic [7:0] OP_INVOKESTATIC = 8'hb8;

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_OP    = 3'd1,
    S_ARG1  = 3'd2,
    S_ARG2  = 3'd3,
    S_VALID = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/opcode_argc.sv
// Combinational opcode -> operand-count lookup.
// Ports:
//   opcode : in  8      opcode byte
//   argc   : out ARGC_W number of operand bytes following the opcode (0..2)
// Any opcode not listed has no operands.
module opcode_argc
  import bali_pkg::*;
(
  input  logic [7:0] opcode,
  output argc_t      argc
);

  always_comb begin
    argc = argc_t'(0);
    if (opcode inside {OP_BIPUSH, OP_LDC, OP_ILOAD, OP_ISTORE}) begin
      argc = argc_t'(1);
    end else if (opcode inside {OP_SIPUSH, OP_IINC, OP_INVOKESTATIC,
                                [OP_IF_FIRST:OP_GOTO]}) begin
      argc = argc_t'(2);
    end
  end

endmodule

// File: rtl/bytecode_fetch.sv
// Instruction fetch stage: reads the variable-length bytecode stream from a
// byte-wide synchronous program memory and assembles opcode + 0..2 operands.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   en                    : allow a new opcode fetch to start
//   mem_rd, mem_addr      : program memory read strobe / byte address
//   mem_data              : read data, valid the cycle after mem_rd
//   instr_valid/ready     : instruction handshake to decode/execute
//   opcode, arg1, arg2    : assembled instruction bytes (unused args are 0)
//   argc, instr_pc        : operand count, address of the opcode byte
//   jmp, jmp_addr         : redirect to a new fetch address
//   fetch_state           : current state machine state (observability)
//
// Handshake: an instruction transfers on a cycle where instr_valid and
// instr_ready are both high and jmp is low. While instr_valid is high and not
// transferred, all instruction outputs hold their values. instr_valid never
// drops without a transfer except on jmp or reset.
module bytecode_fetch
  import bali_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [7:0]            opcode,
  output logic [7:0]            arg1,
  output logic [7:0]            arg2,
  output argc_t                 argc,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  jmp,
  input  logic [ADDR_WIDTH-1:0] jmp_addr,
  output fetch_state_t          fetch_state
);

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PC_TWO = ADDR_WIDTH'(2);

  fetch_state_t          state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc;
  argc_t                 lut_argc;

  // Looked up on the raw memory byte so the OP state can decide whether an
  // operand read is needed in the same cycle the opcode arrives.
  opcode_argc u_opcode_argc (
    .opcode (mem_data),
    .argc   (lut_argc)
  );

  // State register and instruction datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      opcode   <= '0;
      arg1     <= '0;
      arg2     <= '0;
      argc     <= '0;
      instr_pc <= '0;
    end else begin
      state <= state_nxt;
      if (jmp) begin
        pc <= jmp_addr;
      end else begin
        case (state)
          S_OP: begin
            opcode   <= mem_data;
            instr_pc <= pc;
            arg1     <= '0;
            arg2     <= '0;
            argc     <= lut_argc;
          end
          S_ARG1: arg1 <= mem_data;
          S_ARG2: arg2 <= mem_data;
          S_VALID: begin
            if (instr_ready) begin
              pc <= pc + PC_ONE + ADDR_WIDTH'(argc);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Next state and memory strobes. pc keeps pointing at the opcode byte for
  // the whole instruction; operand addresses are offsets from it and wrap.
  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    mem_addr  = pc;
    if (rst || jmp) begin
      state_nxt = S_REQ;
    end else begin
      case (state)
        S_REQ: begin
          if (en) begin
            mem_rd    = 1'b1;
            state_nxt = S_OP;
          end
        end
        S_OP: begin
          if (lut_argc != argc_t'(0)) begin
            mem_rd    = 1'b1;
            mem_addr  = pc + PC_ONE;
            state_nxt = S_ARG1;
          end else begin
            state_nxt = S_VALID;
          end
        end
        S_ARG1: begin
          if (argc == argc_t'(2)) begin
            mem_rd    = 1'b1;
            mem_addr  = pc + PC_TWO;
            state_nxt = S_ARG2;
          end else begin
            state_nxt = S_VALID;
          end
        end
        S_ARG2:  state_nxt = S_VALID;
        S_VALID: if (instr_ready) state_nxt = S_REQ;
        default: state_nxt = S_REQ;
      endcase
    end
  end

  // Moore outputs.
  always_comb begin
    instr_valid = (state == S_VALID);
    fetch_state = state;
  end

endmodule

// File: tb/tb_bytecode_fetch.sv
module tb_bytecode_fetch;
  import bali_pkg::*;

  localparam int W = 16 + 8 + 8 + 8 + 2;  // {instr_pc, opcode, arg1, arg2, argc}

  logic         clk, rst, en, mem_rd, instr_valid, instr_ready, jmp;
  logic [15:0]  mem_addr, instr_pc, jmp_addr;
  logic [7:0]   mem_data, opcode, arg1, arg2;
  argc_t        argc;
  fetch_state_t fetch_state;

  logic [7:0]   mem [0:65535];
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           fails  = 0;

  bytecode_fetch #(.ADDR_WIDTH(16), .RESET_PC(16'hfffe)) dut (
    .clk(clk), .rst(rst), .en(en), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_data(mem_data), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .arg1(arg1), .arg2(arg2), .argc(argc), .instr_pc(instr_pc),
    .jmp(jmp), .jmp_addr(jmp_addr), .fetch_state(fetch_state)
  );

  // ---------------- clock / reset / memory ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem[mem_addr];
  end

  // ---------------- reference model ----------------
  function automatic int ref_argc(input logic [7:0] op);
    if (op == 8'h10 || op == 8'h12 || op == 8'h15 || op == 8'h36) return 1;
    if (op == 8'h11 || op == 8'h84 || op == 8'hb8 || (op >= 8'h99 && op <= 8'ha7)) return 2;
    return 0;
  endfunction

  // Walk the program image from start and queue the next n instructions.
  function automatic void push_stream(input logic [15:0] start, input int n);
    logic [15:0] p = start;
    logic [7:0]  op, a1, a2;
    int          c;
    for (int i = 0; i < n; i++) begin
      op = mem[p];
      c  = ref_argc(op);
      a1 = (c >= 1) ? mem[p + 16'd1] : 8'h00;
      a2 = (c == 2) ? mem[p + 16'd2] : 8'h00;
      exp_q.push_back({p, op, a1, a2, 2'(c)});
      p = p + 16'(1 + c);
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic         prev_hold = 1'b0;
  logic         prev_jmp  = 1'b0;
  logic [W-1:0] prev_word, cur_word, exp_word;

  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
      prev_jmp  = 1'b0;
    end else begin
      cur_word = {instr_pc, opcode, arg1, arg2, argc};
      if (jmp) chk("jmp_cycle_mem_rd", 64'(mem_rd), 64'd0);
      if (prev_jmp) chk("valid_after_jmp", 64'(instr_valid), 64'd0);
      if (instr_valid) chk("valid_no_mem_rd", 64'(mem_rd), 64'd0);
      if (prev_hold) begin
        chk("hold_valid", 64'(instr_valid), 64'd1);
        chk("hold_stable", 64'(cur_word), 64'(prev_word));
      end
      if (instr_valid && instr_ready && !jmp) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_accept actual=%0h required=none", cur_word);
        end else begin
          exp_word = exp_q.pop_front();
          chk("instr", 64'(cur_word), 64'(exp_word));
        end
      end
      prev_hold = instr_valid && !instr_ready && !jmp;
      prev_jmp  = jmp;
      prev_word = cur_word;
    end
  end

  // ---------------- driver tasks ----------------
  // rmode 0: ready whenever an instruction is expected; 1: random; 2: never.
  task automatic step(input int rmode, input bit ren);
    @(posedge clk);
    #1;
    jmp = 1'b0;
    case (rmode)
      0:       instr_ready = (exp_q.size() > 0);
      1:       instr_ready = (exp_q.size() > 0) && ($urandom_range(0, 3) != 0);
      default: instr_ready = 1'b0;
    endcase
    en = ren ? ($urandom_range(0, 4) != 0) : 1'b1;
  endtask

  task automatic jump(input logic [15:0] a);
    @(posedge clk);
    #1;
    jmp         = 1'b1;
    jmp_addr    = a;
    instr_ready = 1'b0;
    en          = 1'b1;
    exp_q.delete();
    #1;
    chk("jmp_mem_rd_low", 64'(mem_rd), 64'd0);
  endtask

  task automatic drain(input int budget, input int rmode);
    while (exp_q.size() > 0 && budget > 0) begin
      step(rmode, rmode == 1);
      budget--;
    end
    if (exp_q.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Valid-rise cycles counted from the jmp cycle, with en=1 and ready=1.
  task automatic timed(input logic [15:0] a, input int t0, input int t1, input int t2);
    int c = 0;
    int k = 0;
    int want[3];
    want[0] = t0; want[1] = t1; want[2] = t2;
    jump(a);
    push_stream(a, 3);
    while (k < 3 && c < 40) begin
      step(0, 1'b0);
      c++;
      if (instr_valid) begin
        chk($sformatf("valid_cycle_%0d", k), 64'(c), 64'(want[k]));
        k++;
      end
    end
    if (k < 3) chk("timed_timeout", 64'(k), 64'd3);
    drain(20, 0);
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] cap;
  logic [15:0]  t;
  int           n, stop, budget, found;

  initial begin
    rst = 1'b1; en = 1'b0; instr_ready = 1'b0; jmp = 1'b0; jmp_addr = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 16'h1000; i < 16'h1100; i++) begin
      case ($urandom_range(0, 7))
        0: mem[i] = 8'h10;
        1: mem[i] = 8'h11;
        2: mem[i] = 8'h84;
        3: mem[i] = 8'(8'h99 + $urandom_range(0, 14));
        4: mem[i] = 8'hb8;
        5: mem[i] = 8'h15;
        6: mem[i] = 8'($urandom_range(0, 255));
        default: mem[i] = 8'h60;
      endcase
    end
    mem[16'hfffe] = 8'h11; mem[16'hffff] = 8'haa; mem[0] = 8'hbb;
    mem[1] = 8'h60; mem[2] = 8'h64; mem[3] = 8'h68;
    mem[16'h10] = 8'h10; mem[16'h11] = 8'h05; mem[16'h12] = 8'h11;
    mem[16'h13] = 8'h12; mem[16'h14] = 8'h34; mem[16'h15] = 8'h60;
    mem[16'h20] = 8'h84; mem[16'h21] = 8'h03; mem[16'h22] = 8'hff; mem[16'h23] = 8'h60;
    mem[16'h40] = 8'hff; mem[16'h41] = 8'h60;
    mem[16'h100] = 8'ha7;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", 64'({instr_valid, mem_rd, opcode, arg1, arg2, argc, instr_pc}), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'hfffe);
    chk("rst_state", 64'(fetch_state), 64'(S_REQ));
    rst = 1'b0;

    // Wrap through the top of memory, then the stream at 0x0001.
    push_stream(16'hfffe, 4);
    drain(200, 1);

    // Latency / throughput: argc 0 stream, then bipush/sipush/iadd.
    timed(16'h0001, 3, 6, 9);
    timed(16'h0010, 4, 9, 12);

    // Backpressure on iinc.
    jump(16'h0020);
    push_stream(16'h0020, 2);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(2, 1'b0);
      if (instr_valid) found = 1;
    end
    chk("bp_valid_seen", 64'(found), 64'd1);
    cap = {instr_pc, opcode, arg1, arg2, argc};
    chk("bp_word", 64'(cap), 64'({16'h0020, 8'h84, 8'h03, 8'hff, 2'd2}));
    for (int i = 0; i < 5; i++) begin
      step(2, 1'b0);
      chk("bp_no_mem_rd", 64'(mem_rd), 64'd0);
      chk("bp_stable", 64'({instr_valid, instr_pc, opcode, arg1, arg2, argc}), 64'({1'b1, cap}));
    end
    step(0, 1'b0);
    step(0, 1'b0);
    chk("bp_next_fetch", 64'({mem_rd, mem_addr}), 64'({1'b1, 16'h0023}));
    drain(20, 0);

    // Redirect while in ARG1 of goto; target holds an unknown opcode.
    jump(16'h0100);
    step(2, 1'b0); step(2, 1'b0); step(2, 1'b0);
    chk("redir_in_arg1", 64'(fetch_state), 64'(S_ARG1));
    jump(16'h0040);
    push_stream(16'h0040, 2);
    drain(40, 0);

    // Reset asserted in ARG2 of sipush.
    jump(16'h0012);
    step(2, 1'b0); step(2, 1'b0); step(2, 1'b0); step(2, 1'b0);
    chk("rst_mid_in_arg2", 64'(fetch_state), 64'(S_ARG2));
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_outputs", 64'({instr_valid, mem_rd, opcode, arg1, arg2, argc, instr_pc}), 64'd0);
    chk("rst_mid_mem_addr", 64'(mem_addr), 64'hfffe);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_stream(16'hfffe, 4);
    drain(200, 1);

    // Random segments, some cut short by a redirect mid-instruction.
    for (int s = 0; s < 40; s++) begin
      t    = 16'h1000 + 16'($urandom_range(0, 224));
      n    = $urandom_range(2, 6);
      stop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n - 1) : 0;
      jump(t);
      push_stream(t, n);
      budget = 400;
      while (exp_q.size() > stop && budget > 0) begin
        step(1, 1'b1);
        budget--;
      end
      if (exp_q.size() > stop) chk("seg_timeout", 64'(exp_q.size()), 64'(stop));
    end
    jump(16'h0000);
    exp_q.delete();
    step(2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/bytecode_fetch.md
# bytecode_fetch

Instruction fetch stage for the bali Java bytecode core. It reads the variable-length bytecode stream from a synchronous byte-wide program memory and assembles one instruction at a time: an opcode plus 0–2 operand bytes. Each assembled instruction is presented to the decode/execute stage over a valid/ready handshake; the opcode output feeds the existing `decoder`. A redirect input restarts fetching at a branch target.

## Interface
Parameters:
- `ADDR_WIDTH`, default 16: program memory address width; also the PC width.
- `RESET_PC`, default 0: PC loaded on reset.

Ports:
- `clk`  in  1  system clock; everything is rising-edge.
- `rst`  in  1  reset. Asynchronous and active-high.
- `en`  in  1  fetch enable. When low, no new opcode fetch is started; an in-flight instruction still completes.
- `mem_rd`  out  1  program memory read strobe.
- `mem_addr`  out  ADDR_WIDTH  program memory byte address.
- `mem_data`  in  8  read data, valid the cycle after `mem_rd`.
- `instr_valid`  out  1  assembled instruction available.
- `instr_ready`  in  1  consumer accepts the instruction.
- `opcode`  out  8  instruction opcode byte.
- `arg1`, `arg2`  out  8 each  operand bytes, in stream order; 0 when unused.
- `argc`  out  2  operand count, 0–2.
- `instr_pc`  out  ADDR_WIDTH  address of the opcode byte.
- `jmp`  in  1  redirect request.
- `jmp_addr`  in  ADDR_WIDTH  redirect target.

## Operation
- Internal state: `pc` and a state machine with states REQ, OP, ARG1, ARG2, VALID.
- **REQ:** if `en`, drive `mem_rd`=1 and `mem_addr`=`pc`, then go to OP. Otherwise `mem_rd`=0 and stay in REQ.
- **OP:** latch `opcode`=`mem_data`, `instr_pc`=`pc`, clear `arg1`/`arg2`, and set `argc` from the lookup table.
  - If argc≥1: drive `mem_rd`=1, `mem_addr`=`pc`+1, go to ARG1.
  - Otherwise go to VALID.
- **ARG1:** latch `arg1`.
  - If argc=2: `mem_rd`=1, `mem_addr`=`pc`+2, go to ARG2.
  - Otherwise go to VALID.
- **ARG2:** latch `arg2`, go to VALID.
- **VALID:** `instr_valid`=1. All instruction outputs stay stable until `instr_ready`. On accept, `pc` ← `pc`+1+`argc` and the state returns to REQ.
- **Operand-count table** (all other opcodes, including unknown ones, have argc 0):
  - argc 1: 0x10 bipush, 0x12 ldc, 0x15 iload, 0x36 istore.
  - argc 2: 0x11 sipush, 0x84 iinc, 0x99–0xa7 (if*/goto), 0xb8 invokestatic.
- **Redirect:** `jmp`=1 in any state sets `pc` ← `jmp_addr` and state ← REQ. Any partial instruction is discarded.
  - `mem_rd` is forced to 0 during the `jmp` cycle.
  - `jmp` overrides a simultaneous accept: the instruction is not counted as consumed by the fetch unit.
- PC arithmetic is modulo 2^ADDR_WIDTH. Operand fetches wrap through the top of memory.
- **Reset:** state REQ, `pc`=RESET_PC. `instr_valid`, `mem_rd`, `opcode`, `arg1`, `arg2`, `argc`, `instr_pc` are all 0. `mem_addr` shows `pc`. Reset asserted mid-instruction aborts it immediately.

## Timing
- Counting REQ (with `en`) as cycle 0, `instr_valid` rises at cycle 2 for argc 0, cycle 3 for argc 1, and cycle 4 for argc 2.
- Accept cycle → REQ on the next cycle. Peak throughput is one argc-0 instruction every 3 cycles.
- `mem_rd`/`mem_addr` are combinational from state and `pc`. Memory read latency is exactly 1 cycle.
- After `jmp`, `instr_valid` is 0 on the next cycle. The first read of `jmp_addr` is issued on that same cycle if `en`=1.
- `en` dropping while in OP/ARG1/ARG2/VALID has no effect until the return to REQ.

## Structure
- Shared package `bali_pkg`:
  - opcode constants (BIPUSH, SIPUSH, LDC, ILOAD, ISTORE, IINC, IF range bounds, GOTO, INVOKESTATIC);
  - `fetch_state_t` enum;
  - argc width constant.
- Sub-module `opcode_argc`: combinational opcode → argc lookup, instantiated once and reusable by `decoder`.
- Sequential logic in one `always_ff` with async reset; next-state and memory strobes in `always_comb`.

## Test plan
- **Zero-operand stream:** memory 0x60 0x64 0x68 at 0, `en`=1, `instr_ready`=1 → three instructions with `instr_pc` 0, 1, 2, argc 0, valid 3 cycles apart.
- **Operand assembly:** memory 0x10 0x05 0x11 0x12 0x34 0x60 → bipush (arg1=0x05, arg2=0, pc 0); sipush (0x12, 0x34, pc 2); iadd at pc 5.
- **Backpressure:** `instr_ready`=0 for 5 cycles on iinc 0x84 0x03 0xff → outputs stable and no `mem_rd` while held; next opcode fetched from `pc`+3 after accept.
- **Redirect:** `jmp`=1, `jmp_addr`=0x0040 while in ARG1 of 0xa7 → partial instruction dropped; next valid instruction has `instr_pc`=0x0040; `mem_rd`=0 during the `jmp` cycle.
- **Wrap and unknown opcode:** `RESET_PC`=0xfffe, memory[0xfffe]=0x11, [0xffff]=0xaa, [0]=0xbb → arg1=0xaa, arg2=0xbb, next pc 0x0001; an unknown opcode 0xff yields argc 0.
- **Reset mid-fetch:** assert `rst` in ARG2 → all outputs 0 immediately; after release, fetch restarts at `RESET_PC`.
